// File: rtl/alu_pkg.sv
// Shared ALU datapath types and constants: sequencer states, operation encoding,
// and default operand/chunk widths shared with the combinational add unit.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_CHUNK = 16;

endpackage

// File: rtl/add_chunk.sv
// CHUNK-bit ripple slice used once per cycle by the sequential add/subtract unit.
module add_chunk #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign sum   = total[CHUNK-1:0];
  assign cout  = total[CHUNK];

endmodule

// File: rtl/add_sub_seq.sv
// Multi-cycle WIDTH-bit add/subtract: one CHUNK-bit slice per clock through a single
// narrow adder, operands shifted down and result shifted in from the top.
module add_sub_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (((WIDTH % CHUNK) != 0) || (NCHUNK < 2)) begin : g_param_err
    $error("add_sub_seq: WIDTH must be a multiple of CHUNK with at least two chunks");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [CHUNK-1:0] sum_w;
  logic             cout_w;

  add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
    .a    (a_q[CHUNK-1:0]),
    .b    (b_q[CHUNK-1:0]),
    .cin  (carry_q),
    .sum  (sum_w),
    .cout (cout_w)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // SUB is A + ~B + 1: invert B once here and seed the carry with select.
          a_d     = A;
          b_d     = (select == OP_SUB) ? ~B : B;
          carry_d = (select == OP_SUB);
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        res_d   = {sum_w, res_q[WIDTH-1:CHUNK]};
        carry_d = cout_w;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NCHUNK - 1)) begin
          // On the last slice the low chunk of a_q/b_q holds the operand MSBs.
          state_d = DONE;
          cout_d  = cout_w;
          ovf_d   = (a_q[CHUNK-1] == b_q[CHUNK-1]) && (sum_w[CHUNK-1] != a_q[CHUNK-1]);
          zero_d  = ~|res_d;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Result    = res_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_add_sub_seq.sv
// Scoreboard bench for add_sub_seq: directed operations push hand-computed results,
// a negedge monitor compares on every output handshake and checks accept-to-valid latency.
module tb_add_sub_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] A;
  logic [63:0] B;
  logic        select;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] Result;
  logic        carry_out;
  logic        overflow;
  logic        zero;

  add_sub_seq #(.WIDTH(64), .CHUNK(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .select    (select),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    logic        co;
    logic        ov;
    logic        z;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   ntests = 0;
  int   nfail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    ntests++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: latency on out_valid rise, full compare on each handshake.
  initial begin
    logic ov_prev;
    ov_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && !ov_prev) begin
        if (sb.size() == 0) chk("unexpected_out_valid", 64'(out_valid), 64'd0);
        else                chk({sb[0].name, "_latency"}, 64'(cyc - sb[0].acc), 64'd4);
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_result"}, Result, e.res);
        chk({e.name, "_carry"},  64'(carry_out), 64'(e.co));
        chk({e.name, "_ovf"},    64'(overflow),  64'(e.ov));
        chk({e.name, "_zero"},   64'(zero),      64'(e.z));
      end
      ov_prev = out_valid;
    end
  end

  task automatic do_op(input string name, input logic [63:0] a, input logic [63:0] b,
                       input logic sel, input logic [63:0] er, input logic eco,
                       input logic eov, input logic ez);
    exp_t e;
    int   n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk({name, "_in_ready_timeout"}, 64'(in_ready), 64'd1);
    A = a; B = b; select = sel; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = ~a; B = ~b; select = ~sel;
    e.res = er; e.co = eco; e.ov = eov; e.z = ez; e.acc = cyc; e.name = name;
    sb.push_back(e);
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sb.size() != 0) begin
      chk({name, "_response_timeout"}, 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; select = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result",    Result,         64'd0);
    chk("rst_carry",     64'(carry_out), 64'd0);
    chk("rst_ovf",       64'(overflow),  64'd0);
    chk("rst_zero",      64'(zero),      64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("add_0_0", 64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    wait_empty("add_0_0");
    do_op("add_5_3", 64'h5, 64'h3, 1'b0, 64'h8, 1'b0, 1'b0, 1'b0);
    wait_empty("add_5_3");
    do_op("add_pattern", 64'h123456789ABCDEF0, 64'h0FEDCBA987654321, 1'b0,
          64'h2222222222222211, 1'b0, 1'b0, 1'b0);
    wait_empty("add_pattern");
    do_op("add_wrap", 64'hFFFFFFFFFFFFFFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
    wait_empty("add_wrap");
    do_op("add_sovf", 64'h7FFFFFFFFFFFFFFF, 64'h1, 1'b0, 64'h8000000000000000, 1'b0, 1'b1, 1'b0);
    wait_empty("add_sovf");
    do_op("sub_5_3", 64'h5, 64'h3, 1'b1, 64'h2, 1'b1, 1'b0, 1'b0);
    wait_empty("sub_5_3");
    do_op("sub_0_1", 64'h0, 64'h1, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0, 1'b0);
    wait_empty("sub_0_1");
    do_op("sub_equal", 64'h1234, 64'h1234, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1);
    wait_empty("sub_equal");
    do_op("sub_sovf", 64'h8000000000000000, 64'h1, 1'b1, 64'h7FFFFFFFFFFFFFFF, 1'b1, 1'b1, 1'b0);
    wait_empty("sub_sovf");

    // Backpressure: hold out_ready low for three DONE cycles while poking in_valid.
    out_ready = 1'b0;
    do_op("bp", 64'h10, 64'h20, 1'b1, 64'hFFFFFFFFFFFFFFF0, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", 64'(out_valid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_result", Result, 64'hFFFFFFFFFFFFFFF0);
      chk("bp_hold_carry", 64'(carry_out), 64'd0);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      A = 64'hDEAD; B = 64'hBEEF; select = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_in_ready_after", 64'(in_ready), 64'd1);
    chk("bp_out_valid_after", 64'(out_valid), 64'd0);
    chk("bp_popped", 64'(sb.size()), 64'd0);
    do_op("b2b", 64'h5, 64'h3, 1'b0, 64'h8, 1'b0, 1'b0, 1'b0);
    wait_empty("b2b");

    // Reset while counter == 2 abandons the operation.
    do_op("rst_mid", 64'hFFFFFFFFFFFFFFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_in_ready",  64'(in_ready),  64'd1);
    chk("rst_mid_result",    Result,         64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post_rst", 64'h123456789ABCDEF0, 64'h0FEDCBA987654321, 1'b0,
          64'h2222222222222211, 1'b0, 1'b0, 1'b0);
    wait_empty("post_rst");

    repeat (8) @(posedge clk);
    #1;
    chk("idle_at_end", 64'(in_ready), 64'd1);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
